handshake_arbiter: RTL and testbench
====================================

Name: handshake_arbiter

Overview:
Shares one four-phase SEND/ACK peripheral port between NUM_REQ requesters, each running the same SEND/ACK protocol the peripheral FSM expects.
- Round-robin grant; one transaction owns the peripheral at a time.
- Winning requester's data is latched and presented to the peripheral.
- Peripheral ACK is routed back only to the granted requester.
- Sits between the processor-side senders and the fsmPeripheral instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, payload width
TIMEOUT_CYCLES, 16, cycles to wait for peripheral ACK (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_send  in  NUM_REQ  per-requester SEND
req_data  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ack  out  NUM_REQ  per-requester ACK, one-hot or zero
SEND  out  1  SEND to peripheral
outData  out  DATA_WIDTH  data to peripheral
inACK  in  1  ACK from peripheral
grant_id  out  clog2(NUM_REQ)  index of current owner
busy  out  1  high in any state except IDLE
err  out  1  one-cycle timeout pulse (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Outputs: all registered. rst=0 forces state IDLE, round-robin pointer 0, and zero on SEND, outData, req_ack, grant_id, busy and err, regardless of clk. This holds mid-transaction: SEND drops immediately.
- FSM states are IDLE, REQ, ACK and RELEASE.
- IDLE:
  - If any req_send is high, pick the first high bit at or after the pointer, wrapping at NUM_REQ.
  - Next edge: grant_id=g, outData=req_data[g], SEND=1, busy=1, state REQ, pointer=(g+1) mod NUM_REQ.
  - Latency from req_send high to SEND high is 1 cycle.
- REQ:
  - inACK=1 -> ACK, with req_ack[g]=1 next edge.
  - req_send[g]=0 before inACK (withdrawal) -> SEND=0, RELEASE; no req_ack issued.
- ACK:
  - Holds SEND=1 and req_ack[g]=1.
  - When req_send[g]=0 -> SEND=0, req_ack[g]=0, RELEASE.
- RELEASE:
  - Waits for inACK=0, then IDLE with busy=0.
  - The next grant can appear at the earliest 1 cycle after returning to IDLE.
- outData and grant_id are frozen from grant until re-grant; requester data changes after grant are ignored.
- Other requesters' req_ack stays 0 and their requests remain pending, with no loss.
- Simultaneous requests are served in rotation from the pointer. After g is served, g gets lowest priority.
- Peripheral ACK is 1 cycle after SEND, so the minimum transaction is 7 cycles.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ.
  - If it reaches TIMEOUT_CYCLES with inACK=0: SEND=0, err=1 for one cycle, state RELEASE; the requester gets no ack.
- Undefined: no counter; REQ waits indefinitely; err tied 0.

Decomposition:
- Package handshake_arb_pkg:
  - State encoding constants IDLE=0, REQ=1, ACK=2, RELEASE=3 (2-bit state type).
  - Default NUM_REQ and DATA_WIDTH.
  - Grant-index width function.
- Sub-module rr_picker: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: valid, index.
  - Instantiated once.

Test Plan:
- Single request: req_send[2]=1 with data 0xDEADBEEF, peripheral model ACK 1 cycle after SEND. Required response:
  - SEND=1 and outData=0xDEADBEEF, grant_id=2, one cycle later.
  - req_ack[2]=1 two cycles after SEND.
  - After req_send[2] drops, SEND drops next cycle; busy=0 once inACK=0.
- All four requesting continuously from reset: grants occur in order 0, 1, 2, 3, 0; each requester sees exactly one req_ack pulse per grant.
- Mid-transaction reset: rst=0 while in ACK. SEND, req_ack and busy go to 0 before the next clk edge; after release the first grant goes to requester 0.
- Withdrawal: req_send[1] dropped while in REQ before inACK. SEND=0 next cycle; req_ack[1] never asserts; the FSM returns to IDLE after inACK=0.
- Data stability: req_data[0] changed from 0x1 to 0x2 after grant. outData stays 0x1 until the transaction ends.
- ARB_TIMEOUT_EN defined, peripheral never acks, TIMEOUT_CYCLES=16. err pulses exactly 16 cycles after entering REQ; SEND=0 the same edge; the next pending requester is granted afterwards.

Source files
------------

// File: rtl/handshake_arb_pkg.sv
// rtl/handshake_arb_pkg.sv - shared types, defaults and helpers for handshake_arbiter
//
// Purpose: state encoding of the arbiter FSM, default sizing, and the width
//          function used for grant indices and the round-robin pointer.
// Ports:   none (package).

package handshake_arb_pkg;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // A single requester still needs a 1-bit index so ports never collapse to zero width.
  function automatic int grant_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
//
// Purpose: returns the first set request bit at or after ptr, wrapping at NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority index (must be < NUM_REQ)
//   valid out 1        at least one request is set
//   idx   out IDX_W    selected index (0 when valid is low)

module rr_picker
  import handshake_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int               c;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the last hit, which is the
  // one closest to ptr in rotation order, is the one that sticks.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) begin
        c = c - NUM_REQ;
      end
      cand = IDX_W'(c);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter.sv
// rtl/handshake_arbiter.sv - round-robin arbiter sharing one SEND/ACK peripheral port
//
// Purpose: grants one requester at a time, latches its payload toward the
//          peripheral and routes the peripheral ACK back to that requester only.
//          Optional macro ARB_TIMEOUT_EN adds a REQ-state ACK timeout with err pulse.
// Ports:
//   clk       in  1                   clock, rising edge
//   rst       in  1                   asynchronous active-low reset
//   req_send  in  NUM_REQ             per-requester SEND
//   req_data  in  NUM_REQ*DATA_WIDTH  requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack   out NUM_REQ             per-requester ACK, one-hot or zero
//   SEND      out 1                   SEND to peripheral
//   outData   out DATA_WIDTH          payload to peripheral
//   inACK     in  1                   ACK from peripheral
//   grant_id  out GW                  index of current owner
//   busy      out 1                   high whenever the FSM is not IDLE
//   err       out 1                   one-cycle timeout pulse (0 without ARB_TIMEOUT_EN)

module handshake_arbiter
  import handshake_arb_pkg::*;
#(
  parameter  int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter  int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int GW             = grant_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_send,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          SEND,
  output logic [DATA_WIDTH-1:0]         outData,
  input  logic                          inACK,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          err
);

  arb_state_t              state_q, state_d;
  logic                    send_q, send_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [GW-1:0]           gid_q, gid_d;
  logic                    busy_q, busy_d;
  logic [GW-1:0]           ptr_q, ptr_d;

  logic                    pick_valid;
  logic [GW-1:0]           pick_idx;
  logic                    timeout;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GW)
  ) u_picker (
    .req   (req_send),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Fires on the TIMEOUT_CYCLES-th edge spent in REQ, so the counter only
  // needs to reach TIMEOUT_CYCLES-1 before the decision edge.
  assign timeout = (state_q == REQ) && !inACK &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside REQ, which also gives the clear on entry to REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign err = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    data_d  = data_q;
    ack_d   = ack_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = REQ;
          send_d  = 1'b1;
          busy_d  = 1'b1;
          gid_d   = pick_idx;
          data_d  = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          // The winner drops to lowest priority for the next round.
          ptr_d   = (pick_idx == GW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end

      REQ: begin
        // A peripheral ACK wins over a same-cycle withdrawal or timeout.
        if (inACK) begin
          state_d        = ACK;
          ack_d          = '0;
          ack_d[gid_q]   = 1'b1;
        end else if (!req_send[gid_q] || timeout) begin
          state_d = RELEASE;
          send_d  = 1'b0;
        end
      end

      ACK: begin
        if (!req_send[gid_q]) begin
          state_d = RELEASE;
          send_d  = 1'b0;
          ack_d   = '0;
        end
      end

      RELEASE: begin
        if (!inACK) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        send_d  = 1'b0;
        ack_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      send_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  assign SEND     = send_q;
  assign outData  = data_q;
  assign req_ack  = ack_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_handshake_arbiter.sv
// tb/tb_handshake_arbiter.sv - randomized self-checking bench for handshake_arbiter

module tb_handshake_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk      = 1'b0;
  logic            rst      = 1'b1;
  logic [N-1:0]    req_send = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ack;
  logic            SEND;
  logic [DW-1:0]   outData;
  logic            inACK    = 1'b0;
  logic [GW-1:0]   grant_id;
  logic            busy;
  logic            err;

  handshake_arbiter #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_send (req_send),
    .req_data (req_data),
    .req_ack  (req_ack),
    .SEND     (SEND),
    .outData  (outData),
    .inACK    (inACK),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered peripheral: raises inACK ack_dly cycles after it sees SEND,
  // drops it one cycle after SEND falls; mute suppresses ACK entirely.
  int ack_dly = 1;
  bit mute    = 1'b0;
  int hi      = 0;

  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      inACK = 1'b0;
      hi    = 0;
    end else begin
      inACK = (hi >= ack_dly) && !mute;
      hi    = SEND ? hi + 1 : 0;
    end
  end

  // Transaction-level reference model.
  int           m_ptr     = 0;
  int           m_owner   = 0;
  logic [DW-1:0] m_data   = '0;
  bit           send_prev = 1'b0;
  logic [N-1:0] ack_prev  = '0;
  logic [N-1:0] any_ack   = '0;
  int           grants[N];
  int           acks[N];
  int           wd[N];
  int           dly[N];
  int           order[$];
  int           mode      = 0;
  bit           err_quiet = 1'b1;

  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr     = 0;
    m_owner   = 0;
    send_prev = 1'b0;
    ack_prev  = '0;
  endtask

  task automatic tick();
    logic [N-1:0]    r_before;
    logic [N*DW-1:0] d_before;
    int              w;
    r_before = req_send;
    d_before = req_data;
    @(posedge clk);
    #1;
    if (SEND && !send_prev) begin
      w = rr_ref(r_before, m_ptr);
      check("grant_id", 64'(grant_id), 64'(w));
      m_owner = (w < 0) ? 0 : w;
      m_data  = d_before[m_owner*DW +: DW];
      check("grant_data", 64'(outData), 64'(m_data));
      m_ptr = (m_owner + 1) % N;
      grants[m_owner]++;
      order.push_back(m_owner);
    end
    if (SEND) begin
      check("data_hold", 64'(outData), 64'(m_data));
      check("busy_with_send", 64'(busy), 64'(1));
    end
    check("ack_owner_only", 64'(req_ack & ~(N'(1) << m_owner)), 64'(0));
    if (req_ack[m_owner] && !ack_prev[m_owner]) acks[m_owner]++;
    any_ack = any_ack | req_ack;
    if (err_quiet) check("err_quiet", 64'(err), 64'(0));
    send_prev = SEND;
    ack_prev  = req_ack;
    // Four-phase requesters: drop on ACK, re-raise only after ACK falls.
    for (int i = 0; i < N; i++) begin
      if (req_send[i] && req_ack[i]) begin
        req_send[i] = 1'b0;
        dly[i]      = (mode == 2) ? int'($urandom_range(0, 4)) : 0;
      end else if (!req_send[i] && !req_ack[i] && mode != 0) begin
        if (dly[i] > 0) begin
          dly[i]--;
        end else if (mode == 1 || $urandom_range(0, 2) == 0) begin
          req_send[i]          = 1'b1;
          req_data[i*DW +: DW] = $urandom;
        end
      end else if (req_send[i] && mode == 2 && $urandom_range(0, 3) == 0) begin
        req_data[i*DW +: DW] = $urandom;
      end
    end
    if (mode == 2 && !SEND && !inACK) ack_dly = int'($urandom_range(1, 3));
  endtask

  task automatic drain(input string tag);
    int k;
    k    = 0;
    mode = 0;
    while ((req_send != '0 || busy) && k < 300) begin
      tick();
      k++;
    end
    check(tag, 64'(req_send == '0 && !busy), 64'(1));
  endtask

  task automatic apply_reset();
    req_send = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
  endtask

  task automatic check_ack_counts(input string tag);
    for (int i = 0; i < N; i++) begin
      check(tag, 64'(acks[i]), 64'(grants[i] - wd[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int g0;
    int first;
    for (int i = 0; i < N; i++) begin
      grants[i] = 0;
      acks[i]   = 0;
      wd[i]     = 0;
      dly[i]    = 0;
    end

    // Reset state, checked before any clock edge.
    #1 rst = 1'b0;
    #1;
    check("rst_send", 64'(SEND), 64'(0));
    check("rst_ack", 64'(req_ack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gid", 64'(grant_id), 64'(0));
    check("rst_data", 64'(outData), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    model_reset();

    // Single request from requester 2.
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req_send[2]          = 1'b1;
    tick();
    check("t1_send", 64'(SEND), 64'(1));
    check("t1_data", 64'(outData), 64'h0000_0000_DEAD_BEEF);
    check("t1_gid", 64'(grant_id), 64'(2));
    check("t1_busy", 64'(busy), 64'(1));
    tick();
    check("t1_ack_early", 64'(req_ack), 64'(0));
    tick();
    check("t1_ack", 64'(req_ack), 64'b0100);
    tick();
    check("t1_send_drop", 64'(SEND), 64'(0));
    check("t1_ack_drop", 64'(req_ack), 64'(0));
    check("t1_busy_rel", 64'(busy), 64'(1));
    tick();
    check("t1_busy_wait", 64'(busy), 64'(1));
    tick();
    check("t1_idle", 64'(busy), 64'(0));

    // All four requesting continuously from reset.
    apply_reset();
    order.delete();
    mode = 1;
    k    = 0;
    while (order.size() < 5 && k < 100) begin
      tick();
      k++;
    end
    check("rr_count", 64'(order.size()), 64'(5));
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      check("rr_order", 64'(order[i]), 64'(i % N));
    end
    drain("rr_drain");
    check_ack_counts("rr_ack_count");

    // Withdrawal before the peripheral acknowledges.
    ack_dly              = 3;
    any_ack              = '0;
    req_data[1*DW +: DW] = $urandom;
    req_send[1]          = 1'b1;
    tick();
    check("wd_grant", 64'(SEND), 64'(1));
    check("wd_gid", 64'(grant_id), 64'(1));
    req_send[1] = 1'b0;
    wd[1]++;
    tick();
    check("wd_send", 64'(SEND), 64'(0));
    check("wd_busy", 64'(busy), 64'(1));
    tick();
    check("wd_idle", 64'(busy), 64'(0));
    repeat (3) tick();
    check("wd_no_ack", 64'(any_ack[1]), 64'(0));
    ack_dly = 1;

    // Payload frozen after grant.
    req_data[0 +: DW] = 32'h1;
    req_send[0]       = 1'b1;
    tick();
    check("ds_gid", 64'(grant_id), 64'(0));
    check("ds_grant", 64'(outData), 64'h1);
    req_data[0 +: DW] = 32'h2;
    k = 0;
    while (busy && k < 30) begin
      tick();
      k++;
      if (SEND) check("ds_hold", 64'(outData), 64'h1);
    end
    check("ds_done", 64'(busy), 64'(0));
    check("ds_end", 64'(outData), 64'h1);

    // Reset in the middle of an ACK phase.
    req_data[2*DW +: DW] = $urandom;
    req_send[2]          = 1'b1;
    k = 0;
    while (!req_ack[2] && k < 20) begin
      tick();
      k++;
    end
    check("mr_in_ack", 64'(req_ack[2]), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("mr_send", 64'(SEND), 64'(0));
    check("mr_ack", 64'(req_ack), 64'(0));
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_gid", 64'(grant_id), 64'(0));
    check("mr_data", 64'(outData), 64'(0));
    req_send             = 4'b1001;
    req_data[0 +: DW]    = $urandom;
    req_data[3*DW +: DW] = $urandom;
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    tick();
    check("mr_first_send", 64'(SEND), 64'(1));
    check("mr_first_gid", 64'(grant_id), 64'(0));
    drain("mr_drain");
    check_ack_counts("mr_ack_count");

    // Randomized traffic with random peripheral latency and post-grant data churn.
    mode = 2;
    repeat (2000) tick();
    drain("rnd_drain");
    ack_dly = 1;
    check_ack_counts("rnd_ack_count");

`ifdef ARB_TIMEOUT_EN
    // Peripheral never acknowledges.
    err_quiet            = 1'b0;
    mute                 = 1'b1;
    req_data[0 +: DW]    = $urandom;
    req_data[1*DW +: DW] = $urandom;
    req_send[0]          = 1'b1;
    req_send[1]          = 1'b1;
    tick();
    check("to_grant", 64'(SEND), 64'(1));
    first = m_owner;
    k = 0;
    while (!err && k < 40) begin
      tick();
      k++;
    end
    check("to_delay", 64'(k), 64'(TO));
    check("to_send", 64'(SEND), 64'(0));
    wd[first]++;
    tick();
    check("to_pulse", 64'(err), 64'(0));
    mute = 1'b0;
    g0   = order.size();
    k    = 0;
    while (order.size() == g0 && k < 20) begin
      tick();
      k++;
    end
    check("to_regrant", 64'(order.size() > g0), 64'(1));
    check("to_other", 64'(int'(grant_id) == first), 64'(0));
    err_quiet = 1'b1;
    drain("to_drain");
    check_ack_counts("to_ack_count");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
